// File: rtl/mem_dport_ctrl_pkg.sv
// Shared types and helpers for the MEM-stage data-port controller.
// Holds the FSM state enum, funct3 encodings and lane helpers.
package mem_dport_ctrl_pkg;

   localparam int ADDR_W = 32;
   localparam int DATA_W = 32;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      DONE
   } dport_state_t;

   typedef enum logic [2:0] {
      LB  = 3'b000,
      LH  = 3'b001,
      LW  = 3'b010,
      LBU = 3'b100,
      LHU = 3'b101
   } load_funct3_t;

   typedef enum logic [2:0] {
      SB = 3'b000,
      SH = 3'b001,
      SW = 3'b010
   } store_funct3_t;

   function automatic logic access_ok(
      input logic       rd,
      input logic       wr,
      input logic [2:0] f3,
      input logic [1:0] off
   );
      logic ok;
      ok = 1'b0;
      if (rd && !wr) begin
         case (load_funct3_t'(f3))
            LB, LBU: ok = 1'b1;
            LH, LHU: ok = !off[0];
            LW:      ok = (off == 2'b00);
            default: ok = 1'b0;
         endcase
      end else if (wr && !rd) begin
         case (store_funct3_t'(f3))
            SB:      ok = 1'b1;
            SH:      ok = !off[0];
            SW:      ok = (off == 2'b00);
            default: ok = 1'b0;
         endcase
      end
      return ok;
   endfunction

   function automatic logic [3:0] store_mbe(
      input logic [2:0] f3,
      input logic [1:0] off
   );
      logic [3:0] mbe;
      case (store_funct3_t'(f3))
         SB:      mbe = 4'b0001 << off;
         SH:      mbe = 4'b0011 << off;
         default: mbe = 4'b1111;
      endcase
      return mbe;
   endfunction

   // Replicate into every lane so the byte enables alone pick the target.
   function automatic logic [31:0] store_data(
      input logic [2:0]  f3,
      input logic [31:0] wdata
   );
      logic [31:0] d;
      case (store_funct3_t'(f3))
         SB:      d = {4{wdata[7:0]}};
         SH:      d = {2{wdata[15:0]}};
         default: d = wdata;
      endcase
      return d;
   endfunction

endpackage

// File: rtl/mem_dport_ctrl_load_align.sv
// Load data aligner: picks the addressed byte/half of a cache word
// and sign- or zero-extends it according to funct3.
module mem_dport_ctrl_load_align
   import mem_dport_ctrl_pkg::*;
(
   input  logic [31:0] rdata,
   input  logic [1:0]  off,
   input  logic [2:0]  funct3,
   output logic [31:0] result
);

   logic [7:0]  b;
   logic [15:0] h;

   always_comb begin
      case (off)
         2'd0:    b = rdata[7:0];
         2'd1:    b = rdata[15:8];
         2'd2:    b = rdata[23:16];
         default: b = rdata[31:24];
      endcase
      h = off[1] ? rdata[31:16] : rdata[15:0];
      case (load_funct3_t'(funct3))
         LB:      result = {{24{b[7]}}, b};
         LBU:     result = {24'd0, b};
         LH:      result = {{16{h[15]}}, h};
         LHU:     result = {16'd0, h};
         default: result = rdata;
      endcase
   end

endmodule

// File: rtl/mem_dport_ctrl.sv
// MEM-stage data-cache initiator: one cache access per load/store,
// stalls the pipeline until the response, then hands back load data.
module mem_dport_ctrl
   import mem_dport_ctrl_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_read,
   input  logic              req_write,
   input  logic [2:0]        req_funct3,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic              dmem_resp,
   input  logic [DATA_W-1:0] dmem_rdata,
   output logic              dmem_read,
   output logic              dmem_write,
   output logic [ADDR_W-1:0] dmem_address,
   output logic [DATA_W-1:0] dmem_wdata,
   output logic [3:0]        dmem_mbe,
   output logic              stall,
   output logic [DATA_W-1:0] load_rdata,
   output logic              access_err
);

   dport_state_t state_q, state_d;
   logic         issue, complete, legal, req;
   logic [1:0]   off_q;
   logic [2:0]   f3_q;
   logic [31:0]  aligned;

   mem_dport_ctrl_load_align u_align (
      .rdata  (dmem_rdata),
      .off    (off_q),
      .funct3 (f3_q),
      .result (aligned)
   );

   assign req   = req_read | req_write;
   assign legal = access_ok(req_read, req_write, req_funct3, req_addr[1:0]);

   always_comb begin
      state_d    = state_q;
      stall      = 1'b0;
      access_err = 1'b0;
      issue      = 1'b0;
      complete   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (req && legal) begin
               stall   = 1'b1;
               issue   = 1'b1;
               state_d = WAIT;
            end else if (req) begin
               access_err = 1'b1;
            end
         end
         WAIT: begin
            stall = 1'b1;
            if (dmem_resp) begin
               complete = 1'b1;
               state_d  = DONE;
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         dmem_read    <= 1'b0;
         dmem_write   <= 1'b0;
         dmem_address <= '0;
         dmem_wdata   <= '0;
         dmem_mbe     <= 4'b0000;
         load_rdata   <= '0;
         off_q        <= 2'b00;
         f3_q         <= 3'b000;
      end else begin
         state_q <= state_d;
         // Address, lanes and enables stay frozen until the next issue.
         if (issue) begin
            dmem_read    <= req_read;
            dmem_write   <= req_write;
            dmem_address <= {req_addr[ADDR_W-1:2], 2'b00};
            dmem_mbe     <= req_write ? store_mbe(req_funct3, req_addr[1:0])
                                      : 4'b1111;
            dmem_wdata   <= req_write ? store_data(req_funct3, req_wdata)
                                      : '0;
            off_q        <= req_addr[1:0];
            f3_q         <= req_funct3;
         end
         if (complete) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (dmem_read) load_rdata <= aligned;
         end
      end
   end

endmodule
